// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration request arbiter.
package i2c_cfg_pkg;

  localparam int unsigned XFER_W       = 24;
  localparam logic [7:0]  ADV7513_ADDR = 8'h72;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GO,
    ST_WAIT_END,
    ST_BACKOFF,
    ST_DONE
  } state_t;

  // One controller transfer: {slave, sub-address, data}
  typedef struct packed {
    logic [7:0] slave;
    logic [7:0] sub;
    logic [7:0] data;
  } xfer_t;

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Requester and I2C controller signals seen by the arbiter.
interface i2c_req_arbiter_if;
  import i2c_cfg_pkg::*;

  logic [1:0] req_valid;
  xfer_t      req_data0;
  xfer_t      req_data1;
  logic [1:0] req_done;
  logic [1:0] req_err;
  logic       busy;
  logic       ctl_go;
  xfer_t      ctl_data;
  logic       ctl_end;
  logic       ctl_ack;

  modport slave (
    input  req_valid, req_data0, req_data1, ctl_end, ctl_ack,
    output req_done, req_err, busy, ctl_go, ctl_data
  );

  modport master (
    output req_valid, req_data0, req_data1, ctl_end, ctl_ack,
    input  req_done, req_err, busy, ctl_go, ctl_data
  );

endinterface

// File: rtl/i2c_req_arbiter_sync2.sv
// Two-flop synchroniser for single-bit signals from the controller clock domain.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C byte-write controller between two
// requesters, with NACK retry/backoff and a GO-to-END timeout.
module i2c_req_arbiter
  import i2c_cfg_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 2000000,
  parameter int unsigned BACKOFF   = 5000
) (
  input logic              iCLK,
  input logic              iRST_N,
  i2c_req_arbiter_if.slave bus
);

  localparam int unsigned      TMR_W    = 24;
  localparam int unsigned      RTY_W    = 4;
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] BO_LAST  = TMR_W'(BACKOFF - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  state_t           state, state_n;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic [RTY_W-1:0] retry, retry_n;
  logic             last, last_n;
  logic             gnt, gnt_n;
  logic             fail, fail_n;
  logic             pend, pend_n;
  logic             go_q, go_n;
  xfer_t            data_q, data_n;
  logic [1:0]       done_q, done_n;
  logic [1:0]       err_q, err_n;
  logic             busy_q, busy_n;
  logic             end_s, ack_s, end_q;
  logic             end_rise_c;
  logic             pick_c;

  sync2 u_end_sync (.clk(iCLK), .rst_n(iRST_N), .d(bus.ctl_end), .q(end_s));
  sync2 u_ack_sync (.clk(iCLK), .rst_n(iRST_N), .d(bus.ctl_ack), .q(ack_s));

  assign end_rise_c = end_s & ~end_q;
  // Tie goes to whichever requester was not granted last
  assign pick_c = (bus.req_valid == 2'b11) ? ~last : bus.req_valid[1];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state  <= ST_IDLE;
      tmr    <= '0;
      retry  <= '0;
      last   <= 1'b1;
      gnt    <= 1'b0;
      fail   <= 1'b0;
      pend   <= 1'b0;
      go_q   <= 1'b0;
      data_q <= '0;
      done_q <= '0;
      err_q  <= '0;
      busy_q <= 1'b0;
      end_q  <= 1'b0;
    end else begin
      state  <= state_n;
      tmr    <= tmr_n;
      retry  <= retry_n;
      last   <= last_n;
      gnt    <= gnt_n;
      fail   <= fail_n;
      pend   <= pend_n;
      go_q   <= go_n;
      data_q <= data_n;
      done_q <= done_n;
      err_q  <= err_n;
      busy_q <= busy_n;
      end_q  <= end_s;
    end
  end

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    retry_n = retry;
    last_n  = last;
    gnt_n   = gnt;
    fail_n  = fail;
    pend_n  = pend;
    go_n    = go_q;
    data_n  = data_q;
    done_n  = 2'b00;
    err_n   = 2'b00;

    case (state)
      ST_IDLE: begin
        if (bus.req_valid != 2'b00) begin
          gnt_n   = pick_c;
          last_n  = pick_c;
          data_n  = pick_c ? bus.req_data1 : bus.req_data0;
          retry_n = '0;
          state_n = ST_GO;
        end
      end
      ST_GO: begin
        go_n    = 1'b1;
        tmr_n   = '0;
        state_n = ST_WAIT_END;
      end
      ST_WAIT_END: begin
        tmr_n = tmr + TMR_W'(1);
        if (end_rise_c) begin
          go_n = 1'b0;
          if (!ack_s) begin
            fail_n  = 1'b0;
            pend_n  = 1'b1;
            state_n = ST_DONE;
          end else if (retry < RTY_MAX) begin
            retry_n = retry + RTY_W'(1);
            tmr_n   = '0;
            state_n = ST_BACKOFF;
          end else begin
            fail_n  = 1'b1;
            pend_n  = 1'b1;
            state_n = ST_DONE;
          end
        end else if (tmr == TMO_LAST) begin
          go_n    = 1'b0;
          fail_n  = 1'b1;
          pend_n  = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_BACKOFF: begin
        // Backoff only counts once the controller has dropped END
        if (end_s) begin
          tmr_n = '0;
        end else if (tmr == BO_LAST) begin
          state_n = ST_GO;
        end else begin
          tmr_n = tmr + TMR_W'(1);
        end
      end
      ST_DONE: begin
        go_n = 1'b0;
        if (pend) begin
          pend_n = 1'b0;
          done_n = gnt ? 2'b10 : 2'b01;
          err_n  = fail ? done_n : 2'b00;
        end else if (!end_s) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  assign bus.ctl_go   = go_q;
  assign bus.ctl_data = data_q;
  assign bus.req_done = done_q;
  assign bus.req_err  = err_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter: directed scenarios plus randomized
// traffic against a round-robin / retry-count reference model.
module tb_i2c_req_arbiter;
  import i2c_cfg_pkg::*;

  localparam int unsigned MR = 3;
  localparam int unsigned TO = 300;
  localparam int unsigned BO = 20;

  logic iCLK = 1'b0;
  logic iRST_N;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  i2c_req_arbiter_if bus ();

  i2c_req_arbiter #(.MAX_RETRY(MR), .TIMEOUT(TO), .BACKOFF(BO)) dut (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .bus   (bus.slave)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  task automatic do_reset(input logic [1:0] v, input xfer_t d0, input xfer_t d1);
    bus.req_valid = v;
    bus.req_data0 = d0;
    bus.req_data1 = d1;
    bus.ctl_end   = 1'b0;
    bus.ctl_ack   = 1'b0;
    iRST_N        = 1'b0;
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);
  endtask

  task automatic wait_go(input logic lvl, input int budget, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < budget) begin
      @(negedge iCLK);
      cyc++;
      if (bus.ctl_go === lvl) seen = 1'b1;
    end
  endtask

  // Controller model: END high for 3 cycles with the given ACK value
  task automatic ctl_reply(input logic nack);
    bus.ctl_ack = nack;
    bus.ctl_end = 1'b1;
    repeat (3) @(negedge iCLK);
    bus.ctl_end = 1'b0;
  endtask

  // Serve GO assertions, NACKing the first `nacks`, until a done pulse appears
  task automatic run_xfer(input int nacks, output int gos, output int min_gap,
                          output bit data_stable, output xfer_t data_seen,
                          output logic [1:0] done_v, output logic [1:0] err_v,
                          output logic [1:0] done_after, output bit ok);
    int c;
    bit f;
    gos = 0; min_gap = 1 << 30; data_stable = 1'b1; data_seen = '0;
    done_v = 2'b00; err_v = 2'b00; done_after = 2'b00; ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wait_go(1'b1, 400, c, f);
      if (!f) return;
      if (gos > 0) begin
        if (c + 2 < min_gap) min_gap = c + 2;
        if (bus.ctl_data !== data_seen) data_stable = 1'b0;
      end else begin
        data_seen = bus.ctl_data;
      end
      gos++;
      repeat ($urandom_range(0, 4)) @(negedge iCLK);
      ctl_reply(gos <= nacks);
      @(negedge iCLK);
      done_v = bus.req_done;
      err_v  = bus.req_err;
      @(negedge iCLK);
      done_after = bus.req_done;
      if (done_v != 2'b00) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 2'b00; bus.ctl_end = 1'b0; bus.ctl_ack = 1'b0;
    bus.req_data0 = '0; bus.req_data1 = '0;
    iRST_N = 1'b0;
    repeat (2) @(negedge iCLK);
    total_cnt++; if (bus.ctl_go !== 1'b0) $display("FAIL reset_go: got %b want 0", bus.ctl_go); else pass_cnt++;
    total_cnt++; if (bus.ctl_data !== 24'h0) $display("FAIL reset_data: got %h want 000000", bus.ctl_data); else pass_cnt++;
    total_cnt++; if (bus.req_done !== 2'b00) $display("FAIL reset_done: got %b want 00", bus.req_done); else pass_cnt++;
    total_cnt++; if (bus.req_err !== 2'b00) $display("FAIL reset_err: got %b want 00", bus.req_err); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
    iRST_N = 1'b1;
    @(negedge iCLK);
  endtask

  task automatic test_single();
    xfer_t exp_d, ds;
    int gos, gap;
    bit st, ok;
    logic [1:0] dn, er, da;
    exp_d = '{slave: ADV7513_ADDR, sub: 8'h98, data: 8'h03};
    bus.req_data0 = exp_d;
    bus.req_valid = 2'b01;
    @(negedge iCLK);
    total_cnt++; if (bus.ctl_go !== 1'b0) $display("FAIL single_go_early: got %b want 0", bus.ctl_go); else pass_cnt++;
    @(negedge iCLK);
    total_cnt++; if (bus.ctl_go !== 1'b1) $display("FAIL single_grant_latency: got %b want 1", bus.ctl_go); else pass_cnt++;
    total_cnt++; if (bus.ctl_data !== 24'h729803) $display("FAIL single_data: got %h want 729803", bus.ctl_data); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bus.busy); else pass_cnt++;
    run_xfer(0, gos, gap, st, ds, dn, er, da, ok);
    bus.req_valid = 2'b00;
    total_cnt++; if (gos !== 1) $display("FAIL single_gos: got %0d want 1", gos); else pass_cnt++;
    total_cnt++; if (dn !== 2'b01) $display("FAIL single_done_latency: got %b want 01", dn); else pass_cnt++;
    total_cnt++; if (er !== 2'b00) $display("FAIL single_err: got %b want 00", er); else pass_cnt++;
    total_cnt++; if (da !== 2'b00) $display("FAIL single_done_pulse: got %b want 00", da); else pass_cnt++;
  endtask

  task automatic test_contention();
    xfer_t d0, d1, ds, want;
    int gos, gap, w;
    bit st, ok, idle_seen;
    logic [1:0] dn, er, da;
    d0 = 24'h721470;
    d1 = 24'h72AF16;
    do_reset(2'b11, d0, d1);
    for (int k = 0; k < 6; k++) begin
      w = k % 2;
      want = (w == 1) ? d1 : d0;
      run_xfer(0, gos, gap, st, ds, dn, er, da, ok);
      total_cnt++; if (ds !== want) $display("FAIL contention_data[%0d]: got %h want %h", k, ds, want); else pass_cnt++;
      total_cnt++; if (dn !== ((w == 1) ? 2'b10 : 2'b01)) $display("FAIL contention_done[%0d]: got %b want %b", k, dn, (w == 1) ? 2'b10 : 2'b01); else pass_cnt++;
      idle_seen = 1'b0;
      for (int j = 0; j < 10 && !idle_seen; j++) begin
        if (j > 0) @(negedge iCLK);
        if (bus.busy === 1'b0) idle_seen = 1'b1;
      end
      if (k == 5) bus.req_valid = 2'b00;
      total_cnt++; if (!idle_seen) $display("FAIL contention_idle_gap[%0d]: busy never low, want an idle cycle", k); else pass_cnt++;
    end
  endtask

  task automatic test_nack_retry();
    xfer_t d, ds;
    int gos, gap;
    bit st, ok;
    logic [1:0] dn, er, da;
    d = XFER_W'($urandom);
    do_reset(2'b00, '0, d);
    bus.req_valid = 2'b10;
    run_xfer(2, gos, gap, st, ds, dn, er, da, ok);
    bus.req_valid = 2'b00;
    total_cnt++; if (gos !== 3) $display("FAIL nack_gos: got %0d want 3", gos); else pass_cnt++;
    total_cnt++; if (gap < int'(BO)) $display("FAIL nack_backoff_gap: got %0d want >= %0d", gap, BO); else pass_cnt++;
    total_cnt++; if (!st || ds !== d) $display("FAIL nack_data: got %h stable=%0b want %h", ds, st, d); else pass_cnt++;
    total_cnt++; if (dn !== 2'b10 || er !== 2'b00) $display("FAIL nack_result: got done=%b err=%b want 10/00", dn, er); else pass_cnt++;
  endtask

  task automatic test_persistent_nack();
    xfer_t d, ds;
    int gos, gap, extra;
    bit st, ok;
    logic [1:0] dn, er, da;
    d = XFER_W'($urandom);
    do_reset(2'b01, d, '0);
    run_xfer(100, gos, gap, st, ds, dn, er, da, ok);
    bus.req_valid = 2'b00;
    total_cnt++; if (gos !== int'(MR) + 1) $display("FAIL pnack_gos: got %0d want %0d", gos, MR + 1); else pass_cnt++;
    total_cnt++; if (dn !== 2'b01 || er !== 2'b01) $display("FAIL pnack_result: got done=%b err=%b want 01/01", dn, er); else pass_cnt++;
    extra = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge iCLK);
      if (bus.ctl_go === 1'b1) extra++;
    end
    total_cnt++; if (extra !== 0) $display("FAIL pnack_extra_go: got %0d go cycles want 0", extra); else pass_cnt++;
    d = XFER_W'($urandom);
    bus.req_data1 = d;
    bus.req_valid = 2'b10;
    run_xfer(0, gos, gap, st, ds, dn, er, da, ok);
    bus.req_valid = 2'b00;
    total_cnt++; if (dn !== 2'b10 || er !== 2'b00 || ds !== d) $display("FAIL pnack_next: got done=%b err=%b data=%h want 10/00/%h", dn, er, ds, d); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int c, late;
    bit f;
    do_reset(2'b00, '0, '0);
    bus.req_data0 = XFER_W'($urandom);
    bus.req_valid = 2'b01;
    wait_go(1'b1, 10, c, f);
    total_cnt++; if (!f) $display("FAIL timeout_go_rise: got no GO within %0d cycles want GO", c); else pass_cnt++;
    wait_go(1'b0, int'(TO) + 20, c, f);
    total_cnt++; if (!f || c !== int'(TO)) $display("FAIL timeout_go_fall: got %0d cycles want %0d", c, TO); else pass_cnt++;
    @(negedge iCLK);
    total_cnt++; if (bus.req_done !== 2'b01 || bus.req_err !== 2'b01) $display("FAIL timeout_result: got done=%b err=%b want 01/01", bus.req_done, bus.req_err); else pass_cnt++;
    bus.req_valid = 2'b00;
    late = 0;
    bus.ctl_ack = 1'b0;
    bus.ctl_end = 1'b1;
    for (int j = 0; j < 15; j++) begin
      @(negedge iCLK);
      if (j == 2) bus.ctl_end = 1'b0;
      if (bus.req_done !== 2'b00) late++;
    end
    total_cnt++; if (late !== 0) $display("FAIL timeout_late_end: got %0d done cycles want 0", late); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    xfer_t d, ds;
    int c, gos, gap;
    bit f, st, ok;
    logic [1:0] dn, er, da;
    d = XFER_W'($urandom);
    do_reset(2'b00, '0, d);
    bus.req_valid = 2'b10;
    wait_go(1'b1, 10, c, f);
    repeat (5) @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    total_cnt++; if (bus.ctl_go !== 1'b0 || bus.busy !== 1'b0) $display("FAIL midrst_outputs: got go=%b busy=%b want 0/0", bus.ctl_go, bus.busy); else pass_cnt++;
    total_cnt++; if (bus.ctl_data !== 24'h0 || bus.req_done !== 2'b00) $display("FAIL midrst_data: got data=%h done=%b want 000000/00", bus.ctl_data, bus.req_done); else pass_cnt++;
    @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);
    total_cnt++; if (bus.ctl_go !== 1'b0) $display("FAIL midrst_regrant_early: got %b want 0", bus.ctl_go); else pass_cnt++;
    @(negedge iCLK);
    total_cnt++; if (bus.ctl_go !== 1'b1 || bus.ctl_data !== d) $display("FAIL midrst_regrant: got go=%b data=%h want 1/%h", bus.ctl_go, bus.ctl_data, d); else pass_cnt++;
    run_xfer(0, gos, gap, st, ds, dn, er, da, ok);
    bus.req_valid = 2'b00;
    total_cnt++; if (dn !== 2'b10 || er !== 2'b00) $display("FAIL midrst_done: got done=%b err=%b want 10/00", dn, er); else pass_cnt++;
  endtask

  task automatic test_random_traffic();
    xfer_t d [2];
    xfer_t ds;
    logic [1:0] pat, oh, dn, er, da;
    bit model_last, st, ok;
    int w, r, nacks, gos, gap, exp_gos;
    d[0] = '0; d[1] = '0;
    do_reset(2'b00, '0, '0);
    model_last = 1'b1;
    pat = 2'b00;
    for (int it = 0; it < 16; it++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pat[k] && $urandom_range(0, 1) == 1) begin
          pat[k] = 1'b1;
          d[k] = XFER_W'($urandom);
        end
      end
      if (pat == 2'b00) begin
        r = $urandom_range(0, 1);
        pat[r] = 1'b1;
        d[r] = XFER_W'($urandom);
      end
      bus.req_data0 = d[0];
      bus.req_data1 = d[1];
      bus.req_valid = pat;
      if (pat == 2'b11) w = model_last ? 0 : 1;
      else w = pat[1] ? 1 : 0;
      model_last = (w == 1);
      oh = (w == 1) ? 2'b10 : 2'b01;
      nacks = $urandom_range(0, 5);
      exp_gos = (nacks > int'(MR)) ? int'(MR) + 1 : nacks + 1;
      run_xfer(nacks, gos, gap, st, ds, dn, er, da, ok);
      pat[w] = 1'b0;
      bus.req_valid = pat;
      total_cnt++; if (ds !== d[w] || !st) $display("FAIL rand_data[%0d]: got %h stable=%0b want %h", it, ds, st, d[w]); else pass_cnt++;
      total_cnt++; if (dn !== oh) $display("FAIL rand_done[%0d]: got %b want %b", it, dn, oh); else pass_cnt++;
      total_cnt++; if (er !== ((nacks > int'(MR)) ? oh : 2'b00)) $display("FAIL rand_err[%0d]: got %b want %b", it, er, (nacks > int'(MR)) ? oh : 2'b00); else pass_cnt++;
      total_cnt++; if (gos !== exp_gos) $display("FAIL rand_gos[%0d]: got %0d want %0d", it, gos, exp_gos); else pass_cnt++;
      total_cnt++; if (da !== 2'b00) $display("FAIL rand_done_pulse[%0d]: got %b want 00", it, da); else pass_cnt++;
    end
    bus.req_valid = 2'b00;
  endtask

  initial begin
    iRST_N = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_nack_retry();
    test_persistent_nack();
    test_timeout();
    test_reset_mid();
    test_random_traffic();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
